// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Shares the single register-file write port between the
//                processor writeback path and a queued I/O side channel
//                (shape-button events, sensor values). The processor always
//                wins a contended cycle; I/O writes wait in a small FIFO and
//                drain into idle write cycles. A starvation counter asks the
//                processor for a one-cycle writeback stall when the queue
//                has been blocked for STARVE_LIMIT consecutive cycles.
//
//  Parameters  : DEPTH         I/O FIFO entries (power of two, >= 2)
//                STARVE_LIMIT  blocked cycles before a stall (1..255)
//
//  Ports       : clock             rising-edge clock, shared with the regfile
//                ctrl_reset        synchronous active-high reset
//                proc_we/wreg/wdata processor writeback request
//                io_req_valid/reg/data  I/O write request
//                io_req_ready      FIFO can accept a request this cycle
//                ctrl_writeEnable  register-file write enable
//                ctrl_writeReg     register-file write address
//                data_writeReg     register-file write data
//                io_stall_req      processor must suppress writeback
//                queue_count       FIFO occupancy
//                proc_violation    sticky: processor wrote during a stall
//
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clock,
    input  logic                     ctrl_reset,
    input  logic                     proc_we,
    input  logic [4:0]               proc_wreg,
    input  logic [31:0]              proc_wdata,
    input  logic                     io_req_valid,
    input  logic [4:0]               io_req_reg,
    input  logic [31:0]              io_req_data,
    output logic                     io_req_ready,
    output logic                     ctrl_writeEnable,
    output logic [4:0]               ctrl_writeReg,
    output logic [31:0]              data_writeReg,
    output logic                     io_stall_req,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     proc_violation
);

    localparam int                   c_PTR_W      = $clog2(DEPTH);
    localparam int                   c_CNT_W      = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]   c_FULL       = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0]   c_PTR_ONE    = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [7:0]           c_STARVE_MAX = 8'(STARVE_LIMIT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [4:0]          r_mem_reg  [DEPTH];
    logic [31:0]         r_mem_data [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [7:0]          r_starve;
    logic                r_violation;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_stall;
    logic [4:0]          w_head_reg;
    logic [31:0]         w_head_data;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_FULL);
    assign w_head_reg  = r_mem_reg[r_rd_ptr];
    assign w_head_data = r_mem_data[r_rd_ptr];

    // Ready looks only at registered occupancy: a full FIFO refuses a push
    // even in a cycle that also pops, which keeps the ready path short.
    assign io_req_ready = !w_full && !ctrl_reset;
    assign w_push       = io_req_valid && io_req_ready;

    // Any cycle the processor leaves idle drains one entry, including
    // entries addressed to r0, which are consumed without a write.
    assign w_pop        = !ctrl_reset && !proc_we && !w_empty;

    assign w_stall      = (r_starve == c_STARVE_MAX);
    assign io_stall_req = w_stall && !ctrl_reset;

    assign queue_count    = r_count;
    assign proc_violation = r_violation;

    // ------------------------------------------------------------------
    // Write-port mux: processor first, then FIFO head, else idle.
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'd0;
        if (!ctrl_reset) begin
            if (proc_we) begin
                ctrl_writeEnable = 1'b1;
                ctrl_writeReg    = proc_wreg;
                data_writeReg    = proc_wdata;
            end else if (w_pop && (w_head_reg != 5'd0)) begin
                ctrl_writeEnable = 1'b1;
                ctrl_writeReg    = w_head_reg;
                data_writeReg    = w_head_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed: entries are only read when counted)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_reg[r_wr_ptr]  <= io_req_reg;
            r_mem_data[r_wr_ptr] <= io_req_data;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy, starvation counter, violation flag
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_starve    <= '0;
            r_violation <= 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end

            // Outside reset, a non-empty cycle without a pop means the
            // processor took the port; count it, saturating at the limit so
            // a non-compliant processor keeps the stall request asserted.
            if (w_pop || w_empty) begin
                r_starve <= '0;
            end else if (!w_stall) begin
                r_starve <= r_starve + 8'd1;
            end

            if (proc_we && w_stall) begin
                r_violation <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Self-checking bench for regfile_write_arbiter. A queue-based
//                reference model predicts every output each cycle; directed
//                sequences add literal expectations, then randomized traffic
//                (including stalls, violations and resets) follows.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b1;
    logic        proc_we = 1'b0;
    logic [4:0]  proc_wreg = '0;
    logic [31:0] proc_wdata = '0;
    logic        io_req_valid = 1'b0;
    logic [4:0]  io_req_reg = '0;
    logic [31:0] io_req_data = '0;
    logic        io_req_ready;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        io_stall_req;
    logic [2:0]  queue_count;
    logic        proc_violation;

    int checks = 0;
    int errors = 0;

    regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .proc_we          (proc_we),
        .proc_wreg        (proc_wreg),
        .proc_wdata       (proc_wdata),
        .io_req_valid     (io_req_valid),
        .io_req_reg       (io_req_reg),
        .io_req_data      (io_req_data),
        .io_req_ready     (io_req_ready),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .io_stall_req     (io_stall_req),
        .queue_count      (queue_count),
        .proc_violation   (proc_violation)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: queue of pending writes, blocked-cycle count, flag
    // ------------------------------------------------------------------
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } entry_t;

    entry_t q[$];
    int     m_starve = 0;
    bit     m_viol   = 0;
    bit     m_valid  = 0;

    always begin
        @(negedge clock);
        if (m_valid) begin
            logic        e_we;
            logic [4:0]  e_reg;
            logic [31:0] e_data;
            e_we = 0; e_reg = 0; e_data = 0;
            if (!ctrl_reset) begin
                if (proc_we) begin
                    e_we = 1; e_reg = proc_wreg; e_data = proc_wdata;
                end else if (q.size() > 0 && q[0].r != 5'd0) begin
                    e_we = 1; e_reg = q[0].r; e_data = q[0].d;
                end
            end
            chk("m_ready", 32'(io_req_ready), 32'(!ctrl_reset && q.size() < DEPTH));
            chk("m_we",    32'(ctrl_writeEnable), 32'(e_we));
            chk("m_stall", 32'(io_stall_req), 32'(!ctrl_reset && m_starve == STARVE_LIMIT));
            chk("m_count", 32'(queue_count), 32'(q.size()));
            chk("m_viol",  32'(proc_violation), 32'(m_viol));
            if (e_we) begin
                chk("m_wreg",  32'(ctrl_writeReg), 32'(e_reg));
                chk("m_wdata", data_writeReg, e_data);
            end
        end
        @(posedge clock);
        if (ctrl_reset) begin
            q.delete();
            m_starve = 0;
            m_viol   = 0;
            m_valid  = 1;
        end else begin
            bit pop, push;
            pop  = !proc_we && q.size() > 0;
            push = io_req_valid && q.size() < DEPTH;
            if (proc_we && m_starve == STARVE_LIMIT) m_viol = 1;
            if (pop || q.size() == 0) m_starve = 0;
            else if (m_starve < STARVE_LIMIT) m_starve++;
            if (pop) void'(q.pop_front());
            if (push) begin
                entry_t e;
                e.r = io_req_reg;
                e.d = io_req_data;
                q.push_back(e);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: apply inputs for the next cycle, just after an edge
    // ------------------------------------------------------------------
    task automatic cyc(input logic rs, input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic v, input logic [4:0] vr, input logic [31:0] vd);
        @(posedge clock);
        #1;
        ctrl_reset = rs; proc_we = we; proc_wreg = wr; proc_wdata = wd;
        io_req_valid = v; io_req_reg = vr; io_req_data = vd;
        #1;
    endtask

    initial begin
        // Idle drain
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rst_we", 32'(ctrl_writeEnable), 0);
        chk("rst_ready", 32'(io_req_ready), 0);
        cyc(0, 0, 0, 0, 1, 23, 32'h1);
        chk("post_rst_count", 32'(queue_count), 0);
        chk("post_rst_ready", 32'(io_req_ready), 1);
        chk("post_rst_stall", 32'(io_stall_req), 0);
        cyc(0, 0, 0, 0, 1, 24, 32'h2);
        chk("drain1_we", 32'(ctrl_writeEnable), 1);
        chk("drain1_reg", 32'(ctrl_writeReg), 23);
        chk("drain1_data", data_writeReg, 32'h1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("drain2_reg", 32'(ctrl_writeReg), 24);
        chk("drain2_data", data_writeReg, 32'h2);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("drain_empty", 32'(queue_count), 0);
        chk("drain_idle_we", 32'(ctrl_writeEnable), 0);

        // Contention
        cyc(0, 0, 0, 0, 1, 25, 32'hAB);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 5, 32'h55 + i, 0, 0, 0);
            chk("cont_proc_reg", 32'(ctrl_writeReg), 5);
            chk("cont_held", 32'(queue_count), 1);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("cont_io_reg", 32'(ctrl_writeReg), 25);
        chk("cont_io_data", data_writeReg, 32'hAB);

        // Full / backpressure
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 3, 32'h99, 1, 5'(10 + i), 32'(100 + i));
            if (i >= 4) begin
                chk("full_ready", 32'(io_req_ready), 0);
                chk("full_count", 32'(queue_count), 4);
            end
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            chk("full_order_reg", 32'(ctrl_writeReg), 10 + i);
            chk("full_order_data", data_writeReg, 32'(100 + i));
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("full_drained", 32'(queue_count), 0);

        // Starvation, compliant processor
        cyc(0, 0, 0, 0, 1, 27, 32'h1234);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 4, 32'h4, 0, 0, 0);
            chk("starve_no_stall", 32'(io_stall_req), 0);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("starve_stall", 32'(io_stall_req), 1);
        chk("starve_io_reg", 32'(ctrl_writeReg), 27);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("starve_cleared", 32'(io_stall_req), 0);
        chk("starve_no_viol", 32'(proc_violation), 0);

        // Starvation, violating processor
        cyc(0, 0, 0, 0, 1, 28, 32'h5678);
        for (int i = 0; i < 8; i++) cyc(0, 1, 4, 32'h4, 0, 0, 0);
        cyc(0, 1, 6, 32'h6, 0, 0, 0);
        chk("viol_stall", 32'(io_stall_req), 1);
        chk("viol_proc_wins", 32'(ctrl_writeReg), 6);
        cyc(0, 1, 6, 32'h6, 0, 0, 0);
        chk("viol_set", 32'(proc_violation), 1);
        chk("viol_saturated", 32'(io_stall_req), 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("viol_io_reg", 32'(ctrl_writeReg), 28);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("viol_sticky", 32'(proc_violation), 1);

        // Reg-0 discard
        cyc(0, 0, 0, 0, 1, 0, 32'hFFFF);
        cyc(0, 0, 0, 0, 1, 26, 32'h7);
        chk("r0_no_we", 32'(ctrl_writeEnable), 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("r0_next_reg", 32'(ctrl_writeReg), 26);
        chk("r0_next_data", data_writeReg, 32'h7);

        // Reset mid-backlog
        for (int i = 0; i < 3; i++) cyc(0, 1, 2, 32'h2, 1, 5'(1 + i), 32'(i));
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("bk_rst_we", 32'(ctrl_writeEnable), 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("bk_count", 32'(queue_count), 0);
        chk("bk_ready", 32'(io_req_ready), 1);
        chk("bk_no_write", 32'(ctrl_writeEnable), 0);
        chk("bk_viol_clr", 32'(proc_violation), 0);
        cyc(0, 1, 9, 32'h9, 0, 0, 0);
        chk("bk_we_follows_proc", 32'(ctrl_writeEnable), 1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic stall_now;
            @(posedge clock);
            #1;
            stall_now    = io_stall_req;
            ctrl_reset   = ($urandom_range(0, 149) == 0);
            if (stall_now) proc_we = ($urandom_range(0, 7) == 0);
            else           proc_we = ($urandom_range(0, 9) < 7);
            proc_wreg    = 5'($urandom);
            proc_wdata   = $urandom;
            io_req_valid = ($urandom_range(0, 2) != 0);
            io_req_reg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            io_req_data  = $urandom;
        end
        @(posedge clock);
        #1;
        ctrl_reset = 0; proc_we = 0; io_req_valid = 0;
        repeat (3) @(posedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
